channel_eye_scan_ctrl: RTL and testbench

Sequencer that characterises the behavioural `Channel` model by sweeping the sample phase across the UI. It drives a PRBS7 stimulus into the channel at one bit per UI (N sample clocks). It slices the quantised channel output against a threshold at one phase per measurement window. Per phase it reports the bit-error count and the vertical eye opening. It sits in the RX channel/eye-diagram bench between the TX bit source and the `Channel` instance, and runs entirely in the `Sample_CLK` domain.

---
 rtl/channel_eye_scan_ctrl_if.sv | 29 ++
 rtl/channel_eye_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_channel_eye_scan_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/channel_eye_scan_ctrl_if.sv
// Stimulus/result bundle between the eye-scan sequencer and its bench.
// The sequencer takes the slave side; the driver of Start/Threshold/Ch_sample takes the master side.
interface channel_eye_scan_ctrl_if #(
  parameter int N  = 10,
  parameter int DW = 8
);
  localparam int PW = $clog2(N);

  logic                 Start;
  logic [DW-1:0]        Threshold;
  logic [DW-1:0]        Ch_sample;
  logic                 Data_in_tx;
  logic                 Busy;
  logic                 Done;
  logic                 Res_valid;
  logic [PW-1:0]        Res_phase;
  logic [15:0]          Res_err;
  logic signed [DW:0]   Res_open;

  modport master (
    output Start, Threshold, Ch_sample,
    input  Data_in_tx, Busy, Done, Res_valid, Res_phase, Res_err, Res_open
  );

  modport slave (
    input  Start, Threshold, Ch_sample,
    output Data_in_tx, Busy, Done, Res_valid, Res_phase, Res_err, Res_open
  );
endinterface

// File: rtl/channel_eye_scan_ctrl.sv
// Eye-scan sequencer: drives PRBS7 into the channel at one bit per UI, then
// slices the returned samples at one phase per window and reports the error
// count and vertical eye opening for every phase 0..N-1.
module channel_eye_scan_ctrl #(
  parameter int N            = 10,
  parameter int CH_LAT       = 2,
  parameter int SETTLE_UI    = 16,
  parameter int UI_PER_PHASE = 64,
  parameter int DW           = 8
) (
  input logic                   Sample_CLK,
  input logic                   Rst,
  channel_eye_scan_ctrl_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] S_LAST   = SW'(N - 1);
  localparam logic [31:0]   SETTLE_C = 32'(SETTLE_UI);
  localparam logic [15:0]   WIN_LAST = 16'(UI_PER_PHASE - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, SCAN, REPORT, ALIGN} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      s_q, s_d;
  logic [6:0]         lfsr_q, lfsr_d;
  logic [31:0]        ui_cnt_q, ui_cnt_d;
  logic [15:0]        win_q, win_d;
  logic [SW-1:0]      p_q, p_d;
  logic [DW-1:0]      th_q, th_d;
  logic [15:0]        err_q, err_d;
  logic [DW-1:0]      min1_q, min1_d;
  logic [DW-1:0]      max0_q, max0_d;
  logic               done_q, done_d;
  logic [SW-1:0]      rphase_q, rphase_d;
  logic [15:0]        rerr_q, rerr_d;
  logic signed [DW:0] ropen_q, ropen_d;

  logic          busy;
  logic          tx_bit;
  logic          e_bit;
  logic [SW-1:0] d_idx;
  logic          ge;

  assign busy   = (state_q != IDLE);
  assign tx_bit = busy & lfsr_q[6];
  assign ge     = (bus.Ch_sample >= th_q);

  if (CH_LAT == 0) begin : g_nodly
    assign e_bit = tx_bit;
    assign d_idx = s_q;
  end else begin : g_dly
    localparam int unsigned LAT_U = CH_LAT;
    logic [SW:0] dl_q [LAT_U];

    // Align {tx bit, sample index} with Ch_sample; flushed while idle so stale
    // indices from a previous sweep cannot open the first window early.
    always_ff @(posedge Sample_CLK or posedge Rst) begin
      if (Rst) begin
        for (int unsigned i = 0; i < LAT_U; i++) dl_q[i] <= '0;
      end else if (!busy) begin
        for (int unsigned i = 0; i < LAT_U; i++) dl_q[i] <= '0;
      end else begin
        dl_q[0] <= {tx_bit, s_q};
        for (int unsigned i = 1; i < LAT_U; i++) dl_q[i] <= dl_q[i-1];
      end
    end

    assign e_bit = dl_q[LAT_U-1][SW];
    assign d_idx = dl_q[LAT_U-1][SW-1:0];
  end

  // State and datapath registers.
  always_ff @(posedge Sample_CLK or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      lfsr_q   <= '1;
      ui_cnt_q <= '0;
      win_q    <= '0;
      p_q      <= '0;
      th_q     <= '0;
      err_q    <= '0;
      min1_q   <= '1;
      max0_q   <= '0;
      done_q   <= 1'b0;
      rphase_q <= '0;
      rerr_q   <= '0;
      ropen_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      lfsr_q   <= lfsr_d;
      ui_cnt_q <= ui_cnt_d;
      win_q    <= win_d;
      p_q      <= p_d;
      th_q     <= th_d;
      err_q    <= err_d;
      min1_q   <= min1_d;
      max0_q   <= max0_d;
      done_q   <= done_d;
      rphase_q <= rphase_d;
      rerr_q   <= rerr_d;
      ropen_q  <= ropen_d;
    end
  end

  // Next-state logic: stimulus generation, window sequencing and per-phase statistics.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    lfsr_d   = lfsr_q;
    ui_cnt_d = ui_cnt_q;
    win_d    = win_q;
    p_d      = p_q;
    th_d     = th_q;
    err_d    = err_q;
    min1_d   = min1_q;
    max0_d   = max0_q;
    done_d   = 1'b0;
    rphase_d = rphase_q;
    rerr_d   = rerr_q;
    ropen_d  = ropen_q;

    if (busy) begin
      s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      if (s_q == S_LAST) lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end

    case (state_q)
      IDLE: begin
        if (bus.Start && !done_q) begin
          state_d  = SETTLE;
          s_d      = '0;
          lfsr_d   = '1;
          ui_cnt_d = '0;
          p_d      = '0;
          th_d     = bus.Threshold;
        end
      end
      SETTLE: begin
        if (s_q == S_LAST && ui_cnt_q < SETTLE_C) ui_cnt_d = ui_cnt_q + 32'd1;
        if (ui_cnt_q >= SETTLE_C && d_idx == S_LAST) begin
          state_d = SCAN;
          win_d   = '0;
          err_d   = '0;
          min1_d  = '1;
          max0_d  = '0;
        end
      end
      SCAN: begin
        if (d_idx == p_q) begin
          if ((ge != e_bit) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
          if (e_bit) begin
            if (bus.Ch_sample < min1_q) min1_d = bus.Ch_sample;
          end else begin
            if (bus.Ch_sample > max0_q) max0_d = bus.Ch_sample;
          end
        end
        // Results are captured from the _d values so the last sample of the
        // window (phase N-1 lands on d == N-1) is included.
        if (d_idx == S_LAST) begin
          if (win_q == WIN_LAST) begin
            state_d  = REPORT;
            rphase_d = p_q;
            rerr_d   = err_d;
            ropen_d  = signed'({1'b0, min1_d} - {1'b0, max0_d});
          end else begin
            win_d = win_q + 16'd1;
          end
        end
      end
      REPORT: begin
        if (p_q == S_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          s_d     = '0;
        end else begin
          p_d     = p_q + SW'(1);
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (d_idx == S_LAST) begin
          state_d = SCAN;
          win_d   = '0;
          err_d   = '0;
          min1_d  = '1;
          max0_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Data_in_tx = tx_bit;
  assign bus.Busy       = busy;
  assign bus.Done       = done_q;
  assign bus.Res_valid  = (state_q == REPORT);
  assign bus.Res_phase  = rphase_q;
  assign bus.Res_err    = rerr_q;
  assign bus.Res_open   = ropen_q;
endmodule

// File: tb/tb_channel_eye_scan_ctrl.sv
// Bench for channel_eye_scan_ctrl: a reference PRBS7 and channel models feed
// Ch_sample; expected per-phase results are queued up front and popped on Res_valid.
module tb_channel_eye_scan_ctrl;
  localparam int N    = 10;
  localparam int L    = 2;
  localparam int DW   = 8;
  localparam int SA   = 16;
  localparam int UA   = 64;
  localparam int SC   = 1;
  localparam int UC   = 1;
  localparam int PW   = $clog2(N);
  localparam int TMAX = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_drv = 1'b0;
  logic          sel = 1'b0;
  logic [DW-1:0] th_drv = '0;
  logic [DW-1:0] ch_drv = '0;

  channel_eye_scan_ctrl_if #(.N(N), .DW(DW)) ifa ();
  channel_eye_scan_ctrl_if #(.N(N), .DW(DW)) ifc ();

  assign ifa.Start     = start_drv & ~sel;
  assign ifc.Start     = start_drv & sel;
  assign ifa.Threshold = th_drv;
  assign ifc.Threshold = th_drv;
  assign ifa.Ch_sample = ch_drv;
  assign ifc.Ch_sample = ch_drv;

  channel_eye_scan_ctrl #(.N(N), .CH_LAT(L), .SETTLE_UI(SA), .UI_PER_PHASE(UA), .DW(DW))
    dut_a (.Sample_CLK(clk), .Rst(rst), .bus(ifa.slave));
  channel_eye_scan_ctrl #(.N(N), .CH_LAT(L), .SETTLE_UI(SC), .UI_PER_PHASE(UC), .DW(DW))
    dut_c (.Sample_CLK(clk), .Rst(rst), .bus(ifc.slave));

  always #5 clk = ~clk;

  logic          o_tx, o_busy, o_done, o_valid;
  logic [PW-1:0] o_phase;
  logic [15:0]   o_err;
  logic [DW:0]   o_open;
  assign o_tx    = sel ? ifc.Data_in_tx : ifa.Data_in_tx;
  assign o_busy  = sel ? ifc.Busy       : ifa.Busy;
  assign o_done  = sel ? ifc.Done       : ifa.Done;
  assign o_valid = sel ? ifc.Res_valid  : ifa.Res_valid;
  assign o_phase = sel ? ifc.Res_phase  : ifa.Res_phase;
  assign o_err   = sel ? ifc.Res_err    : ifa.Res_err;
  assign o_open  = sel ? ifc.Res_open   : ifa.Res_open;

  typedef struct { int phase; int err; int open; int cyc; } exp_t;
  exp_t sb[$];
  bit   ref_bits [0:1023];
  int   ch [0:TMAX-1];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_done_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int xbit(input int c);
    return (c < 0) ? 0 : int'(ref_bits[c / N]);
  endfunction

  // Channel models: 0 ideal (delay L), 1 inverted, 2 wrong latency (delay 3), 3 attenuated IIR.
  task automatic prepare(input int mode, input int s_ui, input int u_ui);
    int y, tgt, d0, err, mn, mx, j, v, b;
    exp_t e;
    y  = 10;
    d0 = -1;
    for (int t = 0; t < TMAX; t++) begin
      case (mode)
        0: ch[t] = 255 * xbit(t - L);
        1: ch[t] = 255 * (1 - xbit(t - L));
        2: ch[t] = 255 * xbit(t - 3);
        default: begin
          tgt   = (xbit(t - L) != 0) ? 245 : 10;
          y     = y + (tgt - y) / 3;
          ch[t] = y;
        end
      endcase
    end
    for (int t = L; t < TMAX && d0 < 0; t++)
      if ((t / N) >= s_ui && ((t - L) % N) == N - 1) d0 = (t - L) / N + 1;
    sb.delete();
    for (int p = 0; p < N; p++) begin
      err = 0; mn = 255; mx = 0;
      for (int k = 0; k < u_ui; k++) begin
        j = d0 + p * (u_ui + 1) + k;
        v = ch[L + j * N + p];
        b = int'(ref_bits[j]);
        if (((v >= 128) ? 1 : 0) != b) err++;
        if (b == 1) begin if (v < mn) mn = v; end
        else        begin if (v > mx) mx = v; end
      end
      e.phase = p; e.err = err; e.open = mn - mx;
      e.cyc   = L + (d0 + p * (u_ui + 1) + u_ui) * N;
      sb.push_back(e);
    end
    exp_done_cyc = sb[N-1].cyc + 1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ":tx"},    32'(o_tx),    32'd0);
    chk({tag, ":busy"},  32'(o_busy),  32'd0);
    chk({tag, ":done"},  32'(o_done),  32'd0);
    chk({tag, ":valid"}, 32'(o_valid), 32'd0);
    chk({tag, ":phase"}, 32'(o_phase), 32'd0);
    chk({tag, ":err"},   32'(o_err),   32'd0);
    chk({tag, ":open"},  32'(o_open),  32'd0);
  endtask

  task automatic run_sweep(input string name, input int mode, input bit use_c,
                           input int abort_ph, input bit poke);
    int s_ui, u_ui, reports, dones, last_phase, after, abort_t;
    bit finished;
    exp_t e;
    logic [DW:0] eo;
    s_ui = use_c ? SC : SA;
    u_ui = use_c ? UC : UA;
    reports = 0; dones = 0; last_phase = -1; after = -1; finished = 1'b0;
    prepare(mode, s_ui, u_ui);
    abort_t = (abort_ph > 0) ? sb[abort_ph-1].cyc + 5 * N : -1;
    sel = use_c;
    @(negedge clk);
    chk({name, ":idle_busy"}, 32'(o_busy), 32'd0);
    start_drv = 1'b1;
    th_drv    = 8'd128;
    for (int t = 0; t < TMAX && !finished; t++) begin
      @(negedge clk);
      start_drv = 1'b0;
      if (t == 1) th_drv = 8'd0;
      ch_drv = ch[t][DW-1:0];
      if (poke && t == 50) start_drv = 1'b1;
      if (t < exp_done_cyc) begin
        chk({name, ":tx"},   32'(o_tx),   32'(xbit(t)));
        chk({name, ":busy"}, 32'(o_busy), 32'd1);
      end
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk({name, ":extra_valid"}, 32'(o_valid), 32'd0);
        end else begin
          e  = sb.pop_front();
          eo = e.open[DW:0];
          chk({name, ":phase"}, 32'(o_phase), 32'(e.phase));
          chk({name, ":err"},   32'(o_err),   32'(e.err));
          chk({name, ":open"},  32'(o_open),  32'(eo));
          chk({name, ":rcyc"},  32'(t),       32'(e.cyc));
          if (use_c) chk({name, ":err_le1"}, 32'(o_err <= 16'd1), 32'd1);
          last_phase = e.phase;
          reports++;
        end
      end else if (last_phase >= 0 && (t % 37) == 0) begin
        chk({name, ":hold"}, 32'(o_phase), 32'(last_phase));
      end
      if (after >= 0) begin
        chk({name, ":post_done"}, 32'(o_done), 32'd0);
        chk({name, ":post_busy"}, 32'(o_busy), 32'd0);
        if (t == after + 4) finished = 1'b1;
      end
      if (o_done) begin
        dones++;
        chk({name, ":done_cyc"}, 32'(t), 32'(exp_done_cyc));
        chk({name, ":done_busy"}, 32'(o_busy), 32'd0);
        if (poke) start_drv = 1'b1;
        after = t;
      end
      if (t == abort_t) begin
        #2 rst = 1'b1;
        #1 chk_reset({name, ":async"});
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          chk({name, ":no_done"}, 32'(o_done | o_valid | o_busy), 32'd0);
        end
        sb.delete();
        finished = 1'b1;
      end
    end
    if (abort_ph < 0) begin
      chk({name, ":reports"}, 32'(reports), 32'(N));
      chk({name, ":dones"},   32'(dones),   32'd1);
    end
  endtask

  initial begin
    logic [6:0] r;
    r = 7'h7F;
    for (int i = 0; i < 1024; i++) begin
      ref_bits[i] = r[6];
      r = {r[5:0], r[6] ^ r[5]};
    end
    repeat (3) @(negedge clk);
    sel = 1'b0; #1 chk_reset("reset_a");
    sel = 1'b1; #1 chk_reset("reset_c");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("post_reset");

    run_sweep("ideal",    0, 1'b0, -1, 1'b1);
    run_sweep("inverted", 1, 1'b0, -1, 1'b0);
    run_sweep("wronglat", 2, 1'b0, -1, 1'b0);
    run_sweep("channel",  3, 1'b0, -1, 1'b0);
    run_sweep("abort",    3, 1'b0,  4, 1'b0);
    run_sweep("rerun",    3, 1'b0, -1, 1'b1);
    run_sweep("corner",   3, 1'b1, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, observed no completion, expected summary");
    $fatal(1, "watchdog");
  end
endmodule
